// File: rtl/axis_store_forward_fifo.sv
// Store-and-forward AXI-stream frame buffer: a frame becomes visible downstream only once its
// tlast beat is stored; frames longer than the buffer are discarded whole and flagged on drop.
`timescale 1ns/1ps

module axis_store_forward_fifo #(
   parameter int DSIZE = 8,
   parameter int DEPTH = 16
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [DSIZE-1:0]      s_tdata,
   input  logic                  s_tvalid,
   input  logic                  s_tlast,
   output logic                  s_tready,
   output logic [DSIZE-1:0]      m_tdata,
   output logic                  m_tvalid,
   output logic                  m_tlast,
   input  logic                  m_tready,
   output logic [$clog2(DEPTH):0] frame_cnt,
   output logic                  drop
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
   localparam logic [AW:0] PTR_FULL = (AW+1)'(DEPTH);

   typedef enum logic {
      ST_ACCEPT,
      ST_DROP
   } state_t;

   logic [DSIZE:0] mem [DEPTH];

   state_t      state_q, state_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] wr_cmt_q, wr_cmt_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] frame_cnt_q, frame_cnt_d;
   logic        drop_q, drop_d;

   logic full;
   logic overflow;
   logic wr_hs;
   logic rd_hs;
   logic mem_we;
   logic commit;
   logic rd_last;

   // Full with nothing committed behind rd_ptr means one frame owns the whole buffer.
   assign full     = (wr_ptr_q - rd_ptr_q) == PTR_FULL;
   assign overflow = (state_q == ST_ACCEPT) && full && (rd_ptr_q == wr_cmt_q);

   assign s_tready = !areset && ((state_q == ST_DROP) || !full);
   assign m_tvalid = rd_ptr_q != wr_cmt_q;
   assign {m_tlast, m_tdata} = mem[rd_ptr_q[AW-1:0]];
   assign frame_cnt = frame_cnt_q;
   assign drop      = drop_q;

   assign wr_hs   = s_tvalid && s_tready;
   assign rd_hs   = m_tvalid && m_tready;
   assign mem_we  = (state_q == ST_ACCEPT) && wr_hs;
   assign commit  = mem_we && s_tlast;
   assign rd_last = rd_hs && m_tlast;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      wr_cmt_d    = wr_cmt_q;
      rd_ptr_d    = rd_ptr_q;
      frame_cnt_d = frame_cnt_q;
      drop_d      = 1'b0;

      case (state_q)
         ST_ACCEPT: begin
            if (overflow) begin
               wr_ptr_d = wr_cmt_q;
               drop_d   = 1'b1;
               state_d  = ST_DROP;
            end else if (wr_hs) begin
               wr_ptr_d = wr_ptr_q + PTR_ONE;
               if (s_tlast) begin
                  wr_cmt_d = wr_ptr_q + PTR_ONE;
               end
            end
         end
         ST_DROP: begin
            if (wr_hs && s_tlast) begin
               state_d = ST_ACCEPT;
            end
         end
         default: state_d = ST_ACCEPT;
      endcase

      if (rd_hs) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      if (commit && !rd_last) begin
         frame_cnt_d = frame_cnt_q + PTR_ONE;
      end else if (!commit && rd_last) begin
         frame_cnt_d = frame_cnt_q - PTR_ONE;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q     <= ST_ACCEPT;
         wr_ptr_q    <= '0;
         wr_cmt_q    <= '0;
         rd_ptr_q    <= '0;
         frame_cnt_q <= '0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         wr_cmt_q    <= wr_cmt_d;
         rd_ptr_q    <= rd_ptr_d;
         frame_cnt_q <= frame_cnt_d;
         drop_q      <= drop_d;
      end
   end

   // Storage carries no reset; contents are only observable behind committed pointers.
   always_ff @(posedge aclk) begin
      if (mem_we) begin
         mem[wr_ptr_q[AW-1:0]] <= {s_tlast, s_tdata};
      end
   end

endmodule

// File: tb/tb_axis_store_forward_fifo.sv
// Directed and randomised checks of the store-and-forward frame buffer against a beat scoreboard.
`timescale 1ns/1ps

module tb_axis_store_forward_fifo;

   localparam int DSIZE = 8;
   localparam int DEPTH = 16;

   logic             aclk;
   logic             areset;
   logic [DSIZE-1:0] s_tdata;
   logic             s_tvalid;
   logic             s_tlast;
   logic             s_tready;
   logic [DSIZE-1:0] m_tdata;
   logic             m_tvalid;
   logic             m_tlast;
   logic             m_tready;
   logic [4:0]       frame_cnt;
   logic             drop;

   int checkCount = 0;
   int errorCount = 0;
   int dropCount  = 0;
   int lastWait   = 0;
   logic [8:0] outQ[$];
   logic [8:0] expQ[$];

   axis_store_forward_fifo #(.DSIZE(DSIZE), .DEPTH(DEPTH)) dut (
      .aclk      (aclk),
      .areset    (areset),
      .s_tdata   (s_tdata),
      .s_tvalid  (s_tvalid),
      .s_tlast   (s_tlast),
      .s_tready  (s_tready),
      .m_tdata   (m_tdata),
      .m_tvalid  (m_tvalid),
      .m_tlast   (m_tlast),
      .m_tready  (m_tready),
      .frame_cnt (frame_cnt),
      .drop      (drop)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Output beats and drop pulses are sampled on the falling edge, clear of the active edge.
   always @(negedge aclk) begin
      if (!areset) begin
         if (m_tvalid && m_tready) outQ.push_back({m_tlast, m_tdata});
         if (drop) dropCount++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Presents one beat (called at posedge+1) and returns at posedge+1 after it is accepted.
   task automatic applyStimulus(input logic [7:0] data, input logic last);
      int   waits    = 0;
      logic accepted = 1'b0;
      s_tdata  = data;
      s_tlast  = last;
      s_tvalid = 1'b1;
      while (!accepted) begin
         @(negedge aclk);
         accepted = s_tready;
         @(posedge aclk);
         #1;
         if (!accepted) begin
            waits++;
            if (waits > 1000) begin
               checkOutput("send_timeout", waits, 0);
               accepted = 1'b1;
            end
         end
      end
      lastWait = waits;
   endtask

   task automatic idleCycles(input int n);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic compareQueues(input string tag);
      checkOutput($sformatf("%s_count", tag), outQ.size(), expQ.size());
      for (int i = 0; i < expQ.size() && i < outQ.size(); i++)
         checkOutput($sformatf("%s_beat%0d", tag, i), outQ[i], expQ[i]);
      outQ.delete();
      expQ.delete();
   endtask

   initial begin
      int   dropBase;
      int   expDrops;
      int   nMis;
      int   len;
      logic done;
      logic [8:0] frameQ[$];

      areset   = 1'b1;
      s_tdata  = '0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      m_tready = 1'b0;
      done     = 1'b0;

      #3;
      checkOutput("rst_s_tready", s_tready, 0);
      checkOutput("rst_m_tvalid", m_tvalid, 0);
      checkOutput("rst_frame_cnt", frame_cnt, 0);
      checkOutput("rst_drop", drop, 0);
      @(posedge aclk);
      #1 areset = 1'b0;
      @(posedge aclk);
      #1;
      checkOutput("post_rst_s_tready", s_tready, 1);

      // Test 1: one short frame, released only once tlast is stored.
      $display("[TB] test 1: 4-beat frame");
      m_tready = 1'b1;
      checkOutput("t1_cnt0", frame_cnt, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(8'h11 + 8'(i), i == 3);
         expQ.push_back({i == 3, 8'h11 + 8'(i)});
         if (i < 3) checkOutput($sformatf("t1_mvalid_b%0d", i), m_tvalid, 0);
      end
      checkOutput("t1_mvalid_after", m_tvalid, 1);
      checkOutput("t1_cnt1", frame_cnt, 1);
      idleCycles(8);
      checkOutput("t1_cnt_end", frame_cnt, 0);
      compareQueues("t1");

      // Test 2: exactly DEPTH beats fill the buffer, commit, then drain.
      $display("[TB] test 2: 16-beat frame");
      m_tready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(8'(i), i == 15);
         expQ.push_back({i == 15, 8'(i)});
      end
      checkOutput("t2_s_tready_full", s_tready, 0);
      checkOutput("t2_cnt1", frame_cnt, 1);
      idleCycles(3);
      checkOutput("t2_no_drop", dropCount, 0);
      checkOutput("t2_still_full", s_tready, 0);
      m_tready = 1'b1;
      idleCycles(20);
      checkOutput("t2_s_tready_back", s_tready, 1);
      checkOutput("t2_cnt_end", frame_cnt, 0);
      compareQueues("t2");

      // Test 3: oversize frame is dropped whole; the following frame survives.
      $display("[TB] test 3: 20-beat frame");
      m_tready = 1'b0;
      dropBase = dropCount;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(8'h40 + 8'(i), i == 19);
         if (i == 15) checkOutput("t3_full_stall", s_tready, 0);
         if (i == 16) checkOutput("t3_wait_b17", lastWait, 1);
         if (i > 16) checkOutput($sformatf("t3_wait_b%0d", i + 1), lastWait, 0);
      end
      idleCycles(2);
      checkOutput("t3_drops", dropCount - dropBase, 1);
      checkOutput("t3_cnt", frame_cnt, 0);
      checkOutput("t3_mvalid", m_tvalid, 0);
      m_tready = 1'b1;
      idleCycles(3);
      checkOutput("t3_no_output", outQ.size(), 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(8'hA0 + 8'(i), i == 2);
         expQ.push_back({i == 2, 8'hA0 + 8'(i)});
      end
      idleCycles(8);
      compareQueues("t3");

      // Test 4: back-to-back single-beat frames keep frame_cnt at 1.
      $display("[TB] test 4: single-beat frames");
      m_tready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(8'hC0 + 8'(i), 1'b1);
         expQ.push_back({1'b1, 8'hC0 + 8'(i)});
         checkOutput($sformatf("t4_cnt_b%0d", i), frame_cnt, 1);
      end
      idleCycles(6);
      checkOutput("t4_cnt_end", frame_cnt, 0);
      compareQueues("t4");

      // Test 5: random frame lengths and handshake throttling on both sides.
      $display("[TB] test 5: random frames");
      dropBase = dropCount;
      expDrops = 0;
      fork
         begin
            for (int f = 0; f < 200; f++) begin
               len = $urandom_range(1, 24);
               frameQ.delete();
               for (int b = 0; b < len; b++) begin
                  while ($urandom_range(0, 99) >= 70) idleCycles(1);
                  applyStimulus(8'($urandom_range(0, 255)), b == len - 1);
                  frameQ.push_back({s_tlast, s_tdata});
               end
               if (len <= DEPTH) begin
                  foreach (frameQ[k]) expQ.push_back(frameQ[k]);
               end else begin
                  expDrops++;
               end
            end
            idleCycles(1);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge aclk);
               #1 m_tready = ($urandom_range(0, 99) < 50);
            end
         end
      join
      m_tready = 1'b1;
      for (int c = 0; c < 5000 && m_tvalid; c++) idleCycles(1);
      idleCycles(2);
      checkOutput("t5_drain", m_tvalid, 0);
      checkOutput("t5_drops", dropCount - dropBase, expDrops);
      checkOutput("t5_cnt_end", frame_cnt, 0);
      checkOutput("t5_count", outQ.size(), expQ.size());
      nMis = 0;
      for (int i = 0; i < expQ.size() && i < outQ.size(); i++)
         if (outQ[i] !== expQ[i]) nMis++;
      checkOutput("t5_beat_mismatches", nMis, 0);
      outQ.delete();
      expQ.delete();

      // Test 6: asynchronous reset discards stored and partial frames.
      $display("[TB] test 6: reset mid-frame");
      m_tready = 1'b0;
      dropBase = dropCount;
      applyStimulus(8'hD0, 1'b0);
      applyStimulus(8'hD1, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(8'hF0 + 8'(i), 1'b0);
      checkOutput("t6_pre_cnt", frame_cnt, 1);
      checkOutput("t6_pre_mvalid", m_tvalid, 1);
      s_tvalid = 1'b0;
      #3 areset = 1'b1;
      #1;
      checkOutput("t6_rst_mvalid", m_tvalid, 0);
      checkOutput("t6_rst_s_tready", s_tready, 0);
      checkOutput("t6_rst_cnt", frame_cnt, 0);
      repeat (2) @(posedge aclk);
      #1 areset = 1'b0;
      checkOutput("t6_no_drop", dropCount - dropBase, 0);
      outQ.delete();
      m_tready = 1'b1;
      applyStimulus(8'hE0, 1'b0);
      applyStimulus(8'hE1, 1'b1);
      expQ.push_back({1'b0, 8'hE0});
      expQ.push_back({1'b1, 8'hE1});
      idleCycles(6);
      checkOutput("t6_cnt_end", frame_cnt, 0);
      compareQueues("t6");

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
